// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
// Power-up and lock supervision for the audio clock PLL. Holds the PLL in
// reset, waits for a synchronised and filtered lock indication, then releases
// the downstream system reset. Failed lock attempts are retried a bounded
// number of times before the block parks in FAULT. Single clock domain.
module pll_lock_sequencer #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRIES  = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       soft_rst_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic       lost_lock,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The shared counter only ever has to reach (parameter - 1).
    localparam int CNT_MAX = max_of(max_of(RST_CYCLES, LOCK_TIMEOUT), LOCK_STABLE);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] CNT_SAT      = {CNT_W{1'b1}};
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_HOLD  = 3'd0,
        S_WAIT_LOCK   = 3'd1,
        S_LOCK_FILTER = 3'd2,
        S_RUN         = 3'd3,
        S_FAULT       = 3'd4
    } state_t;

    logic             sync1_r;
    logic             sync2_r;
    logic             locked_s;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [3:0]       retry_r;
    logic [3:0]       retry_next_s;

    logic             pll_rst_r;
    logic             sys_rst_r;
    logic             ready_r;
    logic             fault_r;
    logic             lost_lock_r;
    logic             pll_rst_next_s;
    logic             sys_rst_next_s;
    logic             ready_next_s;
    logic             fault_next_s;
    logic             lost_lock_next_s;

    assign locked_s = sync2_r;

    // Two-flop synchroniser for the asynchronous PLL lock flag.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pll_locked;
            sync2_r <= sync1_r;
        end
    end

    // Next-state, retry bookkeeping and lost-lock detection.
    always_comb begin
        state_next_s     = state_r;
        retry_next_s     = retry_r;
        lost_lock_next_s = 1'b0;
        if (soft_rst_req) begin
            // Restart request overrides everything, including the lost-lock pulse.
            state_next_s = S_RESET_HOLD;
            retry_next_s = 4'd0;
        end else begin
            case (state_r)
                S_RESET_HOLD: begin
                    if (cnt_r == RST_LAST) begin
                        state_next_s = S_WAIT_LOCK;
                    end else begin
                        state_next_s = S_RESET_HOLD;
                    end
                end
                S_WAIT_LOCK: begin
                    // Lock wins over a timeout landing on the same cycle.
                    if (locked_s) begin
                        state_next_s = S_LOCK_FILTER;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        if (retry_r < RETRY_MAX) begin
                            retry_next_s = retry_r + 4'd1;
                            state_next_s = S_RESET_HOLD;
                        end else begin
                            state_next_s = S_FAULT;
                        end
                    end else begin
                        state_next_s = S_WAIT_LOCK;
                    end
                end
                S_LOCK_FILTER: begin
                    // A glitch is not a failed attempt: back to waiting, no retry charged.
                    if (!locked_s) begin
                        state_next_s = S_WAIT_LOCK;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_next_s = S_RUN;
                    end else begin
                        state_next_s = S_LOCK_FILTER;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        lost_lock_next_s = 1'b1;
                        retry_next_s     = 4'd0;
                        state_next_s     = S_RESET_HOLD;
                    end else begin
                        state_next_s = S_RUN;
                    end
                end
                S_FAULT: begin
                    state_next_s = S_FAULT;
                end
                default: begin
                    state_next_s = S_RESET_HOLD;
                    retry_next_s = 4'd0;
                end
            endcase
        end
    end

    // Shared counter: cleared on every state entry, saturates while idling.
    always_comb begin
        cnt_next_s = cnt_r;
        if (soft_rst_req || (state_next_s != state_r)) begin
            cnt_next_s = '0;
        end else if (cnt_r == CNT_SAT) begin
            cnt_next_s = cnt_r;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Output decode from the upcoming state so registered outputs track state.
    always_comb begin
        pll_rst_next_s = 1'b1;
        sys_rst_next_s = 1'b1;
        ready_next_s   = 1'b0;
        fault_next_s   = 1'b0;
        case (state_next_s)
            S_RESET_HOLD: begin
                pll_rst_next_s = 1'b1;
            end
            S_WAIT_LOCK: begin
                pll_rst_next_s = 1'b0;
            end
            S_LOCK_FILTER: begin
                pll_rst_next_s = 1'b0;
            end
            S_RUN: begin
                pll_rst_next_s = 1'b0;
                sys_rst_next_s = 1'b0;
                ready_next_s   = 1'b1;
            end
            S_FAULT: begin
                fault_next_s = 1'b1;
            end
            default: begin
                pll_rst_next_s = 1'b1;
            end
        endcase
    end

    // State, counter, retry count and registered outputs.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_r     <= S_RESET_HOLD;
            cnt_r       <= '0;
            retry_r     <= 4'd0;
            pll_rst_r   <= 1'b1;
            sys_rst_r   <= 1'b1;
            ready_r     <= 1'b0;
            fault_r     <= 1'b0;
            lost_lock_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            retry_r     <= retry_next_s;
            pll_rst_r   <= pll_rst_next_s;
            sys_rst_r   <= sys_rst_next_s;
            ready_r     <= ready_next_s;
            fault_r     <= fault_next_s;
            lost_lock_r <= lost_lock_next_s;
        end
    end

    assign pll_rst   = pll_rst_r;
    assign sys_rst   = sys_rst_r;
    assign ready     = ready_r;
    assign fault     = fault_r;
    assign lost_lock = lost_lock_r;
    assign retry_cnt = retry_r;
    assign state     = state_r;

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Power-up and lock-supervision controller for the audio clock PLL (50 MHz refclk in, 12 MHz codec clock out). Drives the PLL reset, synchronises and filters the PLL locked flag, and issues a system reset request to downstream audio logic only after lock is stable. Retries lock acquisition a bounded number of times, then declares a fault. Runs entirely in the refclk domain; downstream domains synchronise sys_rst themselves.

Parameters:
RST_CYCLES, 16, refclk cycles pll_rst is held high per attempt (>=2)
LOCK_TIMEOUT, 65536, refclk cycles allowed in WAIT_LOCK before an attempt fails (>=4)
LOCK_STABLE, 1024, consecutive cycles locked_s must stay 1 before RUN (>=1)
MAX_RETRIES, 3, additional attempts after the first before FAULT (0..15)

Ports:
refclk  input  1  sole clock, 50 MHz reference
rst  input  1  asynchronous, active-high reset
pll_locked  input  1  PLL locked flag, asynchronous to refclk
soft_rst_req  input  1  single-cycle request to restart the sequence
pll_rst  output  1  reset to PLL, active-high
sys_rst  output  1  downstream reset request, active-high
ready  output  1  1 only in RUN
fault  output  1  1 only in FAULT
lost_lock  output  1  one-cycle pulse when lock drops in RUN
retry_cnt  output  4  failed attempts in current sequence
state  output  3  0 RESET_HOLD, 1 WAIT_LOCK, 2 LOCK_FILTER, 3 RUN, 4 FAULT

Behaviour:
- All outputs registered. Reset values: pll_rst=1, sys_rst=1, ready=0, fault=0, lost_lock=0, retry_cnt=0, state=RESET_HOLD, cnt=0, sync flops=0.
- pll_locked passes through a 2-flop synchroniser -> locked_s; only locked_s is used.
- One shared cnt, cleared on every state entry; width clog2 of max parameter.
- RESET_HOLD: pll_rst=1, sys_rst=1. After exactly RST_CYCLES cycles in the state -> WAIT_LOCK.
- WAIT_LOCK: pll_rst=0, sys_rst=1. locked_s=1 -> LOCK_FILTER. Otherwise, after LOCK_TIMEOUT cycles -> if retry_cnt<MAX_RETRIES: retry_cnt+1, RESET_HOLD; else FAULT. Lock takes priority over timeout on the same cycle.
- LOCK_FILTER: pll_rst=0, sys_rst=1. locked_s=0 at any cycle -> WAIT_LOCK with timeout restarted. retry_cnt is not incremented. LOCK_STABLE consecutive cycles with locked_s=1 -> RUN.
- RUN: pll_rst=0, sys_rst=0, ready=1. locked_s=0 -> lost_lock=1 for one cycle, sys_rst=1, ready=0, retry_cnt cleared, RESET_HOLD, all on the same edge.
- FAULT: pll_rst=1, sys_rst=1, fault=1. Stays until soft_rst_req or rst.
- soft_rst_req=1 in any state has highest priority: clear retry_cnt, clear cnt, go to RESET_HOLD with pll_rst=1 and sys_rst=1 on the next edge. If it occurs in RUN, lost_lock is not pulsed.
- rst asserted mid-operation forces the reset values immediately, asynchronously. The sequence restarts from RESET_HOLD after release.
- Latency in RUN entry: ready rises 3+LOCK_STABLE cycles after pll_locked rises, provided the state is WAIT_LOCK and lock holds.
- Illegal state encodings recover to RESET_HOLD.

Test Plan (RST_CYCLES=8, LOCK_TIMEOUT=100, LOCK_STABLE=20, MAX_RETRIES=2):
1. Release rst, pll_locked high 12 cycles after pll_rst falls -> pll_rst high for exactly 8 cycles; ready/sys_rst change 23 cycles after pll_locked rise; retry_cnt=0.
2. pll_locked held 0 -> pll_rst re-pulses twice (retry_cnt 1, 2); FAULT entered 324 cycles after rst release; fault=1, pll_rst=1.
3. In LOCK_FILTER, pll_locked glitches low for 3 cycles at filter count 10 -> back to WAIT_LOCK, no retry increment; RUN reached 23 cycles after lock returns.
4. In RUN, drop pll_locked -> lost_lock exactly one cycle, 3 cycles after the drop; sys_rst=1, ready=0, state=RESET_HOLD, retry_cnt=0.
5. In FAULT, pulse soft_rst_req -> RESET_HOLD next edge, retry_cnt=0. Lock provided -> normal RUN entry. Also pulse soft_rst_req in RUN -> RESET_HOLD, no lost_lock.
6. Assert rst in LOCK_FILTER and in RUN -> all outputs at reset values without a clock edge; synchroniser cleared.
